// File: rtl/palram_arbiter_if.sv
// palram_arbiter_if: pixel, CPU and palette RAM signals shared by the arbiter and its neighbours
interface palram_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 8
);
  logic          PIX_SLOT;
  logic [AW-1:0] PIX_ADDR;
  logic [DW-1:0] PIX_DATA;
  logic          CPU_REQ;
  logic          CPU_WE;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_DIN;
  logic [DW-1:0] CPU_DOUT;
  logic          CPU_ACK;
  logic          FIFO_FULL;
  logic [AW-1:0] RAM_ADDR;
  logic          RAM_WE;
  logic [DW-1:0] RAM_DIN;
  logic [DW-1:0] RAM_DOUT;
  modport slave (
    input  PIX_SLOT, PIX_ADDR, CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, RAM_DOUT,
    output PIX_DATA, CPU_DOUT, CPU_ACK, FIFO_FULL, RAM_ADDR, RAM_WE, RAM_DIN
  );
  modport master (
    output PIX_SLOT, PIX_ADDR, CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, RAM_DOUT,
    input  PIX_DATA, CPU_DOUT, CPU_ACK, FIFO_FULL, RAM_ADDR, RAM_WE, RAM_DIN
  );
endinterface

// File: rtl/palram_arbiter.sv
// palram_arbiter: shares the palette RAM between pixel slots, posted CPU writes and CPU reads
module palram_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           nRESET,
  palram_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_ISSUE, RD_DATA, ACK, GAP} state_t;
  state_t        r_state, w_next;
  logic [AW-1:0] r_fa [FIFO_DEPTH];
  logic [DW-1:0] r_fd [FIFO_DEPTH];
  logic [PW-1:0] r_rp, r_wp;
  logic [PW:0]   r_cnt;
  logic          r_pix_pend;
  logic [DW-1:0] r_pix, r_dout;
  logic          w_full, w_empty, w_pop, w_push;
  assign w_full  = r_cnt == (PW+1)'(FIFO_DEPTH);
  assign w_empty = r_cnt == '0;
  assign w_pop   = !bus.PIX_SLOT && !w_empty;
  assign w_push  = r_state == IDLE && bus.CPU_REQ && bus.CPU_WE && !w_full;
  assign bus.RAM_WE    = nRESET && w_pop;
  assign bus.RAM_ADDR  = bus.PIX_SLOT ? bus.PIX_ADDR :
                         w_pop ? r_fa[r_rp] :
                         r_state == RD_ISSUE ? bus.CPU_ADDR : bus.PIX_ADDR;
  assign bus.RAM_DIN   = r_fd[r_rp];
  assign bus.PIX_DATA  = r_pix;
  assign bus.CPU_DOUT  = r_dout;
  assign bus.CPU_ACK   = r_state == ACK;
  assign bus.FIFO_FULL = w_full;
  // a read waits until every earlier posted write has drained
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = !bus.CPU_REQ ? IDLE : !bus.CPU_WE ? RD_WAIT : w_full ? IDLE : ACK;
      RD_WAIT:  w_next = w_empty && !bus.PIX_SLOT ? RD_ISSUE : RD_WAIT;
      RD_ISSUE: w_next = bus.PIX_SLOT ? RD_ISSUE : RD_DATA;
      RD_DATA:  w_next = ACK;
      ACK:      w_next = GAP;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      r_state    <= IDLE;
      r_rp       <= '0;
      r_wp       <= '0;
      r_cnt      <= '0;
      r_pix_pend <= 1'b0;
      r_pix      <= '0;
      r_dout     <= '0;
    end else begin
      r_state    <= w_next;
      r_pix_pend <= bus.PIX_SLOT;
      if (r_pix_pend) r_pix <= bus.RAM_DOUT;
      if (r_state == RD_DATA) r_dout <= bus.RAM_DOUT;
      if (w_pop) r_rp <= r_rp + PW'(1);
      if (w_push) r_wp <= r_wp + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
  always_ff @(posedge CLK) begin
    if (nRESET && w_push) begin
      r_fa[r_wp] <= bus.CPU_ADDR;
      r_fd[r_wp] <= bus.CPU_DIN;
    end
  end
endmodule

// File: doc/palram_arbiter.md
Name: palram_arbiter

Overview:
- Shares the single-port palette RAM between the pixel pipeline and the 68k CPU bus.
- The pixel pipeline owns every cycle flagged by PIX_SLOT.
- CPU writes are posted into a small FIFO and drained in free cycles. CPU reads wait for the FIFO to empty, then issue in a free cycle.
- Sits between the pixel mux and the palette RAM instance, and replaces direct RAM hookup.

Parameters:
AW, 13, palette RAM address width
DW, 8, palette RAM data width
FIFO_DEPTH, 4, posted-write FIFO entries (power of two, >=2)

Ports:
CLK  in  1  system clock; all logic on rising edge
nRESET  in  1  reset, synchronous, active-low
PIX_SLOT  in  1  high = this cycle belongs to pixel read
PIX_ADDR  in  AW  pixel palette address, valid when PIX_SLOT=1
PIX_DATA  out  DW  registered pixel palette data
CPU_REQ  in  1  CPU access request, level, held until CPU_ACK
CPU_WE  in  1  1 = write, 0 = read; stable while CPU_REQ=1
CPU_ADDR  in  AW  CPU address; stable while CPU_REQ=1
CPU_DIN  in  DW  CPU write data; stable while CPU_REQ=1
CPU_DOUT  out  DW  CPU read data, valid when CPU_ACK=1 on a read
CPU_ACK  out  1  one-cycle acknowledge
FIFO_FULL  out  1  posted-write FIFO full
RAM_ADDR  out  AW  RAM address, combinational mux
RAM_WE  out  1  RAM write enable, combinational
RAM_DIN  out  DW  RAM write data
RAM_DOUT  in  DW  RAM read data; synchronous RAM, 1-cycle latency

Behaviour:
- Reset (nRESET=0 at edge):
  - FIFO emptied; FSM to IDLE.
  - PIX_DATA, CPU_DOUT, CPU_ACK and the internal pixel/CPU read-pending flags cleared to 0.
  - RAM_WE forced 0 while nRESET=0.
  - A request in flight is dropped without ACK. The CPU must re-present it, or it is re-sampled as new once nRESET=1.
- Port ownership per cycle, in priority order:
  1. PIX_SLOT=1: RAM_ADDR=PIX_ADDR, RAM_WE=0.
  2. FIFO non-empty: pop head; RAM_ADDR/RAM_DIN = head entry, RAM_WE=1.
  3. FSM in RD_ISSUE: RAM_ADDR=CPU_ADDR, RAM_WE=0.
  4. Otherwise RAM_ADDR=PIX_ADDR, RAM_WE=0.
- Pixel latency:
  - Slot in cycle n → RAM_DOUT valid in n+1 → PIX_DATA updated at the end of n+1.
  - PIX_DATA holds its value otherwise.
- FSM states:
  - IDLE:
    - CPU_REQ=1, CPU_WE=1, FIFO not full → push {CPU_ADDR,CPU_DIN}; go to ACK.
    - CPU_REQ=1, CPU_WE=1, FIFO full → stay in IDLE, no push.
    - CPU_REQ=1, CPU_WE=0 → go to RD_WAIT.
  - RD_WAIT: FIFO empty, PIX_SLOT=0 and no pop this cycle → go to RD_ISSUE.
  - RD_ISSUE:
    - This is the RAM read cycle. Because the FIFO is empty, no write can pop this cycle.
    - If PIX_SLOT=1, the pixel wins and the FSM stays in RD_ISSUE.
    - Otherwise go to RD_DATA.
  - RD_DATA: CPU_DOUT<=RAM_DOUT; go to ACK.
  - ACK: CPU_ACK=1 for exactly this cycle; go to GAP.
  - GAP: ignores CPU_REQ for one cycle so a held REQ is not double-counted; go to IDLE.
- Write latency: REQ seen in IDLE → ACK asserted 1 cycle later (posted). Writes reach RAM at the first free cycle.
- Read-after-write coherence: a read never issues before all earlier posted writes have popped.
- Simultaneous push and pop in one cycle are both legal; occupancy is unchanged.
- FIFO_FULL = (count==FIFO_DEPTH), registered from count.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Continuous PIX_SLOT=1 starves the CPU indefinitely. This is by design, as the video timing guarantees blanking gaps.

Test Plan:
- Reset: hold nRESET=0 for 3 cycles with CPU_REQ=1 → CPU_ACK=0, RAM_WE=0, FIFO_FULL=0, PIX_DATA=0. After release, the write is accepted and ACK is seen 1 cycle later.
- Pixel-only: PIX_SLOT=1 every cycle, PIX_ADDR=0x0012, RAM preloaded 0x5A → PIX_DATA=0x5A two edges after the slot. RAM_WE stays 0.
- Posted write under load:
  - PIX_SLOT=1 continuously; write 0x1ABC←0x77 → ACK 1 cycle after REQ, no RAM write.
  - Drop PIX_SLOT for 1 cycle → RAM_WE=1 with addr 0x1ABC, data 0x77.
- FIFO full:
  - PIX_SLOT=1; issue 5 back-to-back writes (DEPTH=4) → 4 ACKs, FIFO_FULL=1, 5th stalls with no ACK.
  - Release PIX_SLOT → pops in order, 5th ACKed after the first pop.
- RAW ordering: write 0x0100←0xA5 then read 0x0100, with PIX_SLOT toggling 1/0 → read returns CPU_DOUT=0xA5. The RAM read cycle occurs strictly after the write pop.
- Read contention: read 0x0040 (RAM=0x3C) while PIX_SLOT=1 for 6 cycles → no ACK during the slots. ACK with CPU_DOUT=0x3C 2 cycles after PIX_SLOT falls.
